riscv_data_mem: RTL and testbench

- Byte-addressable, single-port data memory for the RISC-V core's MEM stage.
- Parametrised successor of the current word-only data memory.
- Replaces the combinational write/read and the one-shot array clear with:
  - clocked writes driven by byte/half/word size,
  - a registered, sign- or zero-extended load path,
  - misalignment detection,
  - a sequential post-reset clear guarded by a ready/valid handshake.

---
 rtl/riscv_mem_pkg.sv | 33 +++
 rtl/mem_load_align.sv | 26 ++
 rtl/riscv_data_mem.sv | 115 +++++++++++
 tb/tb_riscv_data_mem.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_mem_pkg.sv
// Shared definitions for the byte-addressable data memory: access sizes,
// controller states and the lane-select helpers.
package riscv_mem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_t;

    // Lanes touched by an access; the illegal size touches nothing.
    function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] offset);
        case (size)
            SZ_BYTE: return 4'b0001 << offset;
            SZ_HALF: return offset[1] ? 4'b1100 : 4'b0011;
            SZ_WORD: return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] offset);
        case (size)
            SZ_BYTE: return 1'b0;
            SZ_HALF: return offset[0];
            SZ_WORD: return offset != 2'b00;
            default: return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/mem_load_align.sv
// Picks the addressed byte/half/word out of a memory word and sign- or
// zero-extends it to 32 bits.
module mem_load_align
    import riscv_mem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  offset,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    output logic [31:0] data
);

    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    always_comb begin
        sel_byte = 8'(word >> {offset, 3'b000});
        sel_half = offset[1] ? word[31:16] : word[15:0];
        case (size)
            SZ_BYTE: data = {{24{sel_byte[7] & ~is_unsigned}}, sel_byte};
            SZ_HALF: data = {{16{sel_half[15] & ~is_unsigned}}, sel_half};
            default: data = word;
        endcase
    end

endmodule

// File: rtl/riscv_data_mem.sv
// Single-port byte-addressable data memory with clocked stores, a registered
// extended load path, misalignment detection and a post-reset sequential clear.
module riscv_data_mem
    import riscv_mem_pkg::*;
#(
    parameter int ADDR_WIDTH     = 13,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  rsp_valid,
    output logic [31:0]           rsp_rdata,
    output logic                  rsp_misaligned,
    output logic                  busy
);

    localparam int WORDS = 2 ** (ADDR_WIDTH - 2);
    localparam logic [ADDR_WIDTH-3:0] LAST_WORD = '1;

    // A request transfers on a rising edge where req_valid && req_ready;
    // req_ready depends only on state, so nothing is held or queued while busy.
    state_t                  state;
    logic [ADDR_WIDTH-3:0]   clr_ptr;
    logic [31:0]             mem [WORDS];

    logic                    accept;
    logic [ADDR_WIDTH-3:0]   idx;
    logic [1:0]              offset;
    logic                    misaligned;
    logic [3:0]              be;
    logic [31:0]             wdata_lanes;

    logic [31:0]             rd_word;
    logic [1:0]              rd_offset;
    logic [1:0]              rd_size;
    logic                    rd_unsigned;
    logic                    rd_load;
    logic [31:0]             load_data;

    assign busy        = (state == ST_CLEAR);
    assign req_ready   = (state == ST_IDLE);
    assign accept      = req_valid && req_ready;
    assign idx         = req_addr[ADDR_WIDTH-1:2];
    assign offset      = req_addr[1:0];
    assign misaligned  = is_misaligned(req_size, offset);
    assign be          = (accept && req_write && !misaligned) ? byte_en(req_size, offset) : 4'b0000;

    always_comb begin
        case (req_size)
            SZ_BYTE: wdata_lanes = {4{req_wdata[7:0]}};
            SZ_HALF: wdata_lanes = {2{req_wdata[15:0]}};
            default: wdata_lanes = req_wdata;
        endcase
    end

    // Storage and raw read word carry no reset so the array can map to RAM.
    always_ff @(posedge clk) begin
        if (state == ST_CLEAR) begin
            mem[clr_ptr] <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[idx][8*i +: 8] <= wdata_lanes[8*i +: 8];
            end
        end
        if (accept) rd_word <= mem[idx];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;
            clr_ptr        <= '0;
            rsp_valid      <= 1'b0;
            rsp_misaligned <= 1'b0;
            rd_load        <= 1'b0;
            rd_offset      <= 2'b00;
            rd_size        <= SZ_BYTE;
            rd_unsigned    <= 1'b0;
        end else begin
            rsp_valid <= accept;
            case (state)
                ST_CLEAR: begin
                    clr_ptr <= clr_ptr + 1'b1;
                    if (clr_ptr == LAST_WORD) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
            if (accept) begin
                rsp_misaligned <= misaligned;
                rd_load        <= !req_write && !misaligned;
                rd_offset      <= offset;
                rd_size        <= req_size;
                rd_unsigned    <= req_unsigned;
            end
        end
    end

    mem_load_align u_align (
        .word        (rd_word),
        .offset      (rd_offset),
        .size        (rd_size),
        .is_unsigned (rd_unsigned),
        .data        (load_data)
    );

    // Stores and faults report zero; rd_load also masks the unreset read word.
    assign rsp_rdata = rd_load ? load_data : 32'h0;

endmodule

// File: tb/tb_riscv_data_mem.sv
// Self-checking bench for riscv_data_mem: directed scenarios plus a short
// random run against a byte model, responses checked through an expected queue.
module tb_riscv_data_mem;

    localparam int AW = 13;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_write = 1'b0;
    logic [1:0]    req_size = 2'b00;
    logic          req_unsigned = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [31:0]   req_wdata = '0;
    logic          rsp_valid;
    logic [31:0]   rsp_rdata;
    logic          rsp_misaligned;
    logic          busy;

    int tests_run = 0;
    int tests_failed = 0;
    int cyc = 0;

    // {misaligned, rdata} per accepted request, plus the cycle it is due.
    logic [32:0] exp_q[$];
    int          due_q[$];

    riscv_data_mem #(.ADDR_WIDTH(AW), .CLEAR_ON_RESET(1'b1)) dut (
        .clk            (clk),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_write      (req_write),
        .req_size       (req_size),
        .req_unsigned   (req_unsigned),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .rsp_valid      (rsp_valid),
        .rsp_rdata      (rsp_rdata),
        .rsp_misaligned (rsp_misaligned),
        .busy           (busy)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- response scoreboard ----------------
    always @(posedge clk) begin
        logic [32:0] e;
        int          due;
        cyc++;
        #2;
        if (rsp_valid) begin
            tests_run++;
            if (exp_q.size() == 0) begin
                tests_failed++;
                $display("FAIL rsp_unexpected: got valid with rdata=%h, required no response", rsp_rdata);
            end else begin
                e = exp_q.pop_front();
                due = due_q.pop_front();
                if (cyc !== due) begin
                    tests_failed++;
                    $display("FAIL rsp_latency: arrived cycle %0d, required %0d", cyc, due);
                end
                tests_run++;
                if (rsp_rdata !== e[31:0]) begin
                    tests_failed++;
                    $display("FAIL rsp_rdata: got %h, required %h", rsp_rdata, e[31:0]);
                end
                tests_run++;
                if (rsp_misaligned !== e[32]) begin
                    tests_failed++;
                    $display("FAIL rsp_misaligned: got %b, required %b", rsp_misaligned, e[32]);
                end
            end
        end else if (due_q.size() > 0 && due_q[0] <= cyc) begin
            tests_run++;
            tests_failed++;
            e = exp_q.pop_front();
            due = due_q.pop_front();
            $display("FAIL rsp_missing: no response at cycle %0d, required rdata=%h", cyc, e[31:0]);
        end
    end

    // ---------------- driver tasks ----------------
    // Called just after a falling edge; drives one request for one cycle.
    task automatic issue(input logic w, input logic [1:0] sz, input logic uns,
                         input logic [AW-1:0] addr, input logic [31:0] wd,
                         input logic mis, input logic [31:0] exp_data);
        req_valid    = 1'b1;
        req_write    = w;
        req_size     = sz;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wd;
        exp_q.push_back({mis, exp_data});
        due_q.push_back(cyc + 1);
        @(negedge clk);
    endtask

    task automatic idle_bus();
        req_valid = 1'b0;
        req_write = 1'b0;
    endtask

    task automatic drain(input int cycles);
        idle_bus();
        repeat (cycles) @(negedge clk);
    endtask

    // Counts edges until busy drops, bounded; reports any req_ready seen while busy.
    task automatic wait_clear(output int n, output int ready_hits);
        n = 0;
        ready_hits = 0;
        while (busy && n < 5000) begin
            if (req_ready) ready_hits++;
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        int n, hits;
        #3;
        tests_run++;
        if ({rsp_valid, rsp_misaligned, rsp_rdata} !== 34'h0) begin
            tests_failed++;
            $display("FAIL reset_rsp: got valid=%b mis=%b rdata=%h, required all zero", rsp_valid, rsp_misaligned, rsp_rdata);
        end
        tests_run++;
        if (busy !== 1'b1 || req_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_busy: got busy=%b ready=%b, required 1/0", busy, req_ready);
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        wait_clear(n, hits);
        tests_run++;
        if (n !== 2048) begin
            tests_failed++;
            $display("FAIL clear_len: got %0d cycles, required 2048", n);
        end
        tests_run++;
        if (hits !== 0) begin
            tests_failed++;
            $display("FAIL clear_ready: req_ready high in %0d busy cycles, required 0", hits);
        end
        tests_run++;
        if (busy !== 1'b0 || req_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL clear_done: got busy=%b ready=%b, required 0/1", busy, req_ready);
        end
        @(negedge clk);
        issue(1'b0, 2'b10, 1'b0, 13'h1FFC, 32'h0, 1'b0, 32'h0000_0000);
        drain(3);
    endtask

    task automatic test_load_ext();
        issue(1'b1, 2'b10, 1'b0, 13'h0010, 32'hDEAD_BEEF, 1'b0, 32'h0);
        issue(1'b0, 2'b00, 1'b0, 13'h0013, 32'h0, 1'b0, 32'hFFFF_FFDE);
        issue(1'b0, 2'b00, 1'b1, 13'h0013, 32'h0, 1'b0, 32'h0000_00DE);
        issue(1'b0, 2'b01, 1'b0, 13'h0012, 32'h0, 1'b0, 32'hFFFF_DEAD);
        issue(1'b0, 2'b01, 1'b1, 13'h0010, 32'h0, 1'b0, 32'h0000_BEEF);
        issue(1'b0, 2'b00, 1'b0, 13'h0010, 32'h0, 1'b0, 32'hFFFF_FFEF);
        issue(1'b0, 2'b00, 1'b1, 13'h0011, 32'h0, 1'b0, 32'h0000_00BE);
        issue(1'b0, 2'b01, 1'b0, 13'h0010, 32'h0, 1'b0, 32'hFFFF_BEEF);
        issue(1'b0, 2'b10, 1'b1, 13'h0010, 32'h0, 1'b0, 32'hDEAD_BEEF);
        drain(3);
    endtask

    task automatic test_back_to_back();
        issue(1'b1, 2'b10, 1'b0, 13'h0020, 32'h1122_3344, 1'b0, 32'h0);
        issue(1'b1, 2'b00, 1'b0, 13'h0021, 32'h0000_00AA, 1'b0, 32'h0);
        issue(1'b0, 2'b10, 1'b0, 13'h0020, 32'h0, 1'b0, 32'h1122_AA44);
        issue(1'b1, 2'b01, 1'b0, 13'h0022, 32'h1234_BEEF, 1'b0, 32'h0);
        issue(1'b0, 2'b10, 1'b0, 13'h0020, 32'h0, 1'b0, 32'hBEEF_AA44);
        drain(3);
    endtask

    task automatic test_misaligned();
        issue(1'b1, 2'b10, 1'b0, 13'h0030, 32'h0A0B_0C0D, 1'b0, 32'h0);
        issue(1'b0, 2'b01, 1'b0, 13'h0031, 32'h0, 1'b1, 32'h0);
        issue(1'b0, 2'b10, 1'b0, 13'h0032, 32'h0, 1'b1, 32'h0);
        issue(1'b0, 2'b11, 1'b0, 13'h0040, 32'h0, 1'b1, 32'h0);
        issue(1'b1, 2'b10, 1'b0, 13'h0031, 32'hFFFF_FFFF, 1'b1, 32'h0);
        issue(1'b1, 2'b01, 1'b0, 13'h0033, 32'hFFFF_FFFF, 1'b1, 32'h0);
        issue(1'b1, 2'b11, 1'b0, 13'h0030, 32'hFFFF_FFFF, 1'b1, 32'h0);
        issue(1'b0, 2'b10, 1'b0, 13'h0030, 32'h0, 1'b0, 32'h0A0B_0C0D);
        drain(3);
    endtask

    task automatic test_boundary();
        issue(1'b1, 2'b00, 1'b0, 13'h1FFF, 32'h0000_007F, 1'b0, 32'h0);
        issue(1'b0, 2'b00, 1'b0, 13'h1FFF, 32'h0, 1'b0, 32'h0000_007F);
        issue(1'b1, 2'b00, 1'b0, 13'h1FFF, 32'hFFFF_FF80, 1'b0, 32'h0);
        issue(1'b0, 2'b00, 1'b0, 13'h1FFF, 32'h0, 1'b0, 32'hFFFF_FF80);
        issue(1'b0, 2'b01, 1'b1, 13'h1FFE, 32'h0, 1'b0, 32'h0000_8000);
        issue(1'b0, 2'b10, 1'b0, 13'h1FFC, 32'h0, 1'b0, 32'h8000_0000);
        drain(3);
    endtask

    task automatic test_random();
        logic [7:0] model [64];
        for (int i = 0; i < 64; i++) model[i] = 8'h00;
        for (int t = 0; t < 60; t++) begin
            logic [1:0]  sz;
            logic        w, uns;
            logic [31:0] wd, v;
            int          a, n;
            sz  = 2'($urandom_range(0, 2));
            n   = 1 << sz;
            a   = $urandom_range(0, 63) & ~(n - 1);
            w   = 1'($urandom_range(0, 1));
            uns = 1'($urandom_range(0, 1));
            wd  = $urandom;
            v   = 32'h0;
            if (w) begin
                for (int k = 0; k < n; k++) model[a + k] = wd[8*k +: 8];
            end else begin
                for (int k = 0; k < n; k++) v = v | (32'(model[a + k]) << (8 * k));
                if (!uns && sz == 2'b00 && v[7])  v = v | 32'hFFFF_FF00;
                if (!uns && sz == 2'b01 && v[15]) v = v | 32'hFFFF_0000;
            end
            issue(w, sz, uns, 13'(32'h100 + a), wd, 1'b0, v);
        end
        drain(3);
    endtask

    task automatic test_reset_mid();
        int n, hits;
        issue(1'b0, 2'b10, 1'b0, 13'h0010, 32'h0, 1'b0, 32'hDEAD_BEEF);
        idle_bus();
        tests_run++;
        if (rsp_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL midload_pre: got rsp_valid=%b, required 1", rsp_valid);
        end
        reset = 1'b1;
        #1;
        tests_run++;
        if (rsp_valid !== 1'b0 || busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL midload_async: got rsp_valid=%b busy=%b, required 0/1", rsp_valid, busy);
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (500) @(negedge clk);
        tests_run++;
        if (busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL midclear_busy: got busy=%b at cycle 500, required 1", busy);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        wait_clear(n, hits);
        tests_run++;
        if (n !== 2048 || hits !== 0) begin
            tests_failed++;
            $display("FAIL midclear_restart: got %0d cycles (%0d ready), required 2048 (0)", n, hits);
        end
        @(negedge clk);
        issue(1'b0, 2'b10, 1'b0, 13'h0010, 32'h0, 1'b0, 32'h0);
        issue(1'b0, 2'b10, 1'b0, 13'h0020, 32'h0, 1'b0, 32'h0);
        drain(3);
    endtask

    task automatic test_clear_ignore();
        int n, hits;
        reset = 1'b1;
        @(negedge clk);
        req_valid = 1'b1;
        req_write = 1'b1;
        req_size  = 2'b10;
        req_addr  = 13'h0008;
        req_wdata = 32'h0000_0055;
        reset = 1'b0;
        wait_clear(n, hits);
        idle_bus();
        tests_run++;
        if (n !== 2048 || hits !== 0) begin
            tests_failed++;
            $display("FAIL ignore_clear: got %0d cycles (%0d ready), required 2048 (0)", n, hits);
        end
        @(negedge clk);
        issue(1'b0, 2'b10, 1'b0, 13'h0008, 32'h0, 1'b0, 32'h0);
        drain(3);
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_load_ext();
        test_back_to_back();
        test_misaligned();
        test_boundary();
        test_random();
        test_reset_mid();
        test_clear_ignore();
        drain(4);
        tests_run++;
        if (exp_q.size() !== 0) begin
            tests_failed++;
            $display("FAIL queue_empty: %0d responses outstanding, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
